// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the data-memory load/store unit.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam int NUM_LANES = 4;

  typedef enum logic {INIT, RUN} state_t;

  // Byte-write enables for a store of the given size at the given lane.
  function automatic logic [NUM_LANES-1:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: byte_en = 4'b0001 << lane;
      SZ_HALF: byte_en = lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_be_ram.sv
// DEPTH x 32 data array split into byte lanes, one write enable per lane,
// registered read port.
module dmem_be_ram
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                      i_clk,
  input  logic [NUM_LANES-1:0]      i_we,
  input  logic [AW-1:0]             i_waddr,
  input  logic [NUM_LANES-1:0][7:0] i_wdata,
  input  logic                      i_re,
  input  logic [AW-1:0]             i_raddr,
  output logic [NUM_LANES-1:0][7:0] o_rdata
);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_q;

    always_ff @(posedge i_clk) begin
      if (i_we[g]) r_mem[i_waddr] <= i_wdata[g];
      if (i_re)    r_q <= r_mem[i_raddr];
    end

    assign o_rdata[g] = r_q;
  end

endmodule

// File: rtl/dmem_ls_unit.sv
// Byte-addressed load/store unit: zero-fill sweep after reset, then one
// request per cycle with a one-cycle registered response.
module dmem_ls_unit
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        init_done
);

  localparam int AW = $clog2(DEPTH);

  state_t         r_state, w_state_nxt;
  logic [AW-1:0]  r_cnt;

  logic           w_accept, w_err, w_misal, w_oor;
  logic [1:0]     w_lane;
  logic [AW-1:0]  w_widx;
  logic [31:0]    w_wrep;

  logic [3:0]     w_ram_we;
  logic [AW-1:0]  w_ram_waddr;
  logic [31:0]    w_ram_wdata;
  logic           w_ram_re;
  logic [31:0]    w_ram_q;

  logic           r_rsp_valid, r_rsp_err, r_rsp_load, r_unsigned;
  logic [1:0]     r_size, r_lane;
  logic [31:0]    w_sh, w_ext;

  assign req_ready = (r_state == RUN);
  assign init_done = (r_state == RUN);
  assign w_accept  = req_valid & req_ready;
  assign w_lane    = req_addr[1:0];
  assign w_widx    = req_addr[AW+1:2];
  assign w_oor     = |(req_addr >> (AW + 2));
  assign w_err     = w_misal | w_oor;

  always_comb begin
    w_misal = 1'b0;
    case (req_size)
      SZ_HALF: w_misal = req_addr[0];
      SZ_WORD: w_misal = |req_addr[1:0];
      SZ_RSVD: w_misal = 1'b1;
      default: w_misal = 1'b0;
    endcase
  end

  // Store data is right-aligned; replicate so every possible lane sees it.
  always_comb begin
    case (req_size)
      SZ_BYTE: w_wrep = {4{req_wdata[7:0]}};
      SZ_HALF: w_wrep = {2{req_wdata[15:0]}};
      default: w_wrep = req_wdata;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ram_we    = 4'b0000;
    w_ram_waddr = w_widx;
    w_ram_wdata = w_wrep;
    w_ram_re    = 1'b0;
    case (r_state)
      INIT: begin
        w_ram_we    = 4'b1111;
        w_ram_waddr = r_cnt;
        w_ram_wdata = 32'h0;
        if (r_cnt == AW'(DEPTH - 1)) w_state_nxt = RUN;
      end
      RUN: begin
        if (w_accept && !w_err) begin
          if (req_we) w_ram_we = byte_en(req_size, w_lane);
          else        w_ram_re = 1'b1;
        end
      end
      default: w_state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == INIT) r_cnt <= r_cnt + 1'b1;
    end
  end

  dmem_be_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .i_clk   (clk),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata),
    .i_re    (w_ram_re),
    .i_raddr (w_widx),
    .o_rdata (w_ram_q)
  );

  // Load metadata travels alongside the synchronous read so lane selection
  // and extension happen on the registered RAM output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_load  <= 1'b0;
      r_unsigned  <= 1'b0;
      r_size      <= SZ_BYTE;
      r_lane      <= 2'b00;
    end else begin
      r_rsp_valid <= w_accept;
      r_rsp_err   <= w_accept & w_err;
      r_rsp_load  <= w_accept & ~w_err & ~req_we;
      if (w_accept) begin
        r_unsigned <= req_unsigned;
        r_size     <= req_size;
        r_lane     <= w_lane;
      end
    end
  end

  assign w_sh = w_ram_q >> {r_lane, 3'b000};

  always_comb begin
    case (r_size)
      SZ_BYTE: w_ext = r_unsigned ? {24'h0, w_sh[7:0]}  : {{24{w_sh[7]}}, w_sh[7:0]};
      SZ_HALF: w_ext = r_unsigned ? {16'h0, w_sh[15:0]} : {{16{w_sh[15]}}, w_sh[15:0]};
      default: w_ext = w_ram_q;
    endcase
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_load ? w_ext : 32'h0;

endmodule
